mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one shared RAM port between an instruction fetch requester and a data requester.
// Data always wins; each access ends with a one-cycle hit pulse, or an abort once ram_busy times out.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        iren,
    input  logic [31:0] iaddr,
    input  logic        dren,
    input  logic        dwen,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ihit,
    output logic        dhit,
    output logic        err,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        ramREN,
    output logic        ramWEN,
    input  logic [31:0] ramload,
    input  logic        ram_busy
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [31:0] ABORT_WORD = 32'hBAD0_BAD0;

    typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   wait_cnt;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_store;
    logic            acc_wr;
    logic            resp_d;
    logic            done;
    logic            abort;
    logic            grant_d;
    logic [31:0]     grant_addr;

    assign grant_d    = dren | dwen;
    assign grant_addr = grant_d ? daddr : iaddr;

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = 32'h0;
        ramstore   = 32'h0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    next_state = DACC;
                end else if (iren) begin
                    next_state = IACC;
                end
            end
            IACC, DACC: begin
                // Access parameters were captured at grant so a dropped request still completes.
                ramaddr  = acc_addr;
                ramWEN   = acc_wr;
                ramREN   = ~acc_wr;
                ramstore = acc_wr ? acc_store : 32'h0;
                if (!ram_busy) begin
                    done = 1'b1;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    abort = 1'b1;
                end
                if (done || abort) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            acc_addr  <= 32'h0;
            acc_store <= 32'h0;
            acc_wr    <= 1'b0;
            resp_d    <= 1'b0;
            err       <= 1'b0;
            iload     <= 32'h0;
            dload     <= 32'h0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state != IDLE) begin
                acc_addr  <= grant_addr & 32'hFFFF_FFFC;
                acc_store <= dstore;
                acc_wr    <= dwen;
                resp_d    <= grant_d;
                wait_cnt  <= '0;
            end else if ((state == IACC || state == DACC) && ram_busy) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (done && !acc_wr) begin
                if (resp_d) dload <= ramload;
                else        iload <= ramload;
            end
            if (abort) begin
                err <= 1'b1;
                if (resp_d) dload <= ABORT_WORD;
                else        iload <= ABORT_WORD;
            end
        end
    end

    assign ihit = (state == RESP) && !resp_d;
    assign dhit = (state == RESP) && resp_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a transaction-level reference model.
// The bench plays the RAM, choosing how many busy cycles each access sees.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        nRST;
    logic        iren, dren, dwen, ram_busy;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        ihit, dhit, err, ramREN, ramWEN;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_iload = 32'h0;
    logic [31:0] exp_dload = 32'h0;
    logic        exp_err   = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .nRST(nRST), .iren(iren), .iaddr(iaddr), .dren(dren), .dwen(dwen),
        .daddr(daddr), .dstore(dstore), .iload(iload), .dload(dload), .ihit(ihit),
        .dhit(dhit), .err(err), .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN),
        .ramWEN(ramWEN), .ramload(ramload), .ram_busy(ram_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction, starting in IDLE with requests already driven.
    // b = number of busy cycles the RAM reports before it would complete.
    task automatic do_txn(input int b, input bit drop_mid, input logic [31:0] rdata);
        logic        is_d, is_w, to;
        logic [31:0] a, st;
        int          len;
        is_d = dren | dwen;
        is_w = dwen;
        a    = (is_d ? daddr : iaddr) & 32'hFFFF_FFFC;
        st   = is_w ? dstore : 32'h0;
        to   = (b >= TO);
        len  = to ? TO : b + 1;

        vectors++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ihit !== 1'b0 || dhit !== 1'b0) begin
            miscompares++;
            $display("FAIL idle: ren=%b wen=%b ihit=%b dhit=%b, required all 0",
                     ramREN, ramWEN, ihit, dhit);
        end
        step();
        for (int k = 0; k < len; k++) begin
            vectors++;
            if (ramREN !== ~is_w || ramWEN !== is_w || ramaddr !== a || ramstore !== st ||
                ihit !== 1'b0 || dhit !== 1'b0) begin
                miscompares++;
                $display("FAIL access cycle %0d: ren=%b wen=%b addr=%h store=%h hit=%b%b, required ren=%b wen=%b addr=%h store=%h hit=00",
                         k, ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, ~is_w, is_w, a, st);
            end
            ram_busy = (k < b);
            ramload  = rdata;
            if (drop_mid && k == 0) begin
                if (is_d) begin dren = 1'b0; dwen = 1'b0; end
                else iren = 1'b0;
            end
            step();
        end

        if (to) begin
            exp_err = 1'b1;
            if (is_d) exp_dload = 32'hBAD0_BAD0;
            else      exp_iload = 32'hBAD0_BAD0;
        end else if (!is_w) begin
            if (is_d) exp_dload = rdata;
            else      exp_iload = rdata;
        end

        vectors++;
        if (ihit !== ~is_d || dhit !== is_d || iload !== exp_iload || dload !== exp_dload ||
            err !== exp_err || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
            miscompares++;
            $display("FAIL resp: ihit=%b dhit=%b iload=%h dload=%h err=%b ren=%b wen=%b, required ihit=%b dhit=%b iload=%h dload=%h err=%b ren=0 wen=0",
                     ihit, dhit, iload, dload, err, ramREN, ramWEN, ~is_d, is_d, exp_iload,
                     exp_dload, exp_err);
        end
        if (is_d) begin dren = 1'b0; dwen = 1'b0; end
        else iren = 1'b0;
        ram_busy = 1'b0;
        step();

        vectors++;
        if (ihit !== 1'b0 || dhit !== 1'b0 || iload !== exp_iload || dload !== exp_dload) begin
            miscompares++;
            $display("FAIL post: ihit=%b dhit=%b iload=%h dload=%h, required 0 0 %h %h",
                     ihit, dhit, iload, dload, exp_iload, exp_dload);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0; iren = 1'b0; dren = 1'b0; dwen = 1'b0; ram_busy = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0;
        step();
        step();
        vectors++;
        if ({ramREN, ramWEN, ihit, dhit, err} !== 5'b0 || ramaddr !== 32'h0 ||
            ramstore !== 32'h0 || iload !== 32'h0 || dload !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: ren=%b wen=%b ihit=%b dhit=%b err=%b addr=%h store=%h iload=%h dload=%h, required all 0",
                     ramREN, ramWEN, ihit, dhit, err, ramaddr, ramstore, iload, dload);
        end
        nRST = 1'b1;
    endtask

    task automatic test_single_fetch();
        iren = 1'b1; iaddr = 32'h104;
        do_txn(0, 1'b0, 32'h0050_0093);
    endtask

    task automatic test_simultaneous();
        iren = 1'b1; iaddr = 32'h0000_0340;
        dren = 1'b1; daddr = 32'h0000_0200;
        do_txn(1, 1'b0, 32'h1234_5678);
        do_txn(0, 1'b0, 32'h8765_4321);
    endtask

    task automatic test_write_busy();
        dwen = 1'b1; daddr = 32'h203; dstore = 32'hCAFE_F00D;
        do_txn(3, 1'b0, 32'hDEAD_BEEF);
    endtask

    task automatic test_timeout();
        dren = 1'b1; daddr = 32'h0000_0410;
        do_txn(20, 1'b0, 32'h5555_AAAA);
        iren = 1'b1; iaddr = 32'h0000_0108;
        do_txn(0, 1'b0, 32'h0000_0013);
    endtask

    task automatic test_reset_mid();
        dren = 1'b1; daddr = 32'h0000_0600;
        step();
        ram_busy = 1'b1;
        step();
        #2;
        nRST = 1'b0;
        #1;
        vectors++;
        if ({ramREN, ramWEN, ihit, dhit, err} !== 5'b0 || ramaddr !== 32'h0 ||
            iload !== 32'h0 || dload !== 32'h0) begin
            miscompares++;
            $display("FAIL reset mid: ren=%b wen=%b ihit=%b dhit=%b err=%b addr=%h iload=%h dload=%h, required all 0",
                     ramREN, ramWEN, ihit, dhit, err, ramaddr, iload, dload);
        end
        dren = 1'b0; ram_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (dhit !== 1'b0 || ihit !== 1'b0) begin
                miscompares++;
                $display("FAIL reset hold %0d: ihit=%b dhit=%b, required 0 0", i, ihit, dhit);
            end
        end
        #2;
        nRST = 1'b1;
        exp_iload = 32'h0; exp_dload = 32'h0; exp_err = 1'b0;
        iren = 1'b1; iaddr = 32'h0000_0ABC;
        do_txn(1, 1'b0, 32'h0F0F_0F0F);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            if (!iren) begin
                iren  = 1'($urandom_range(0, 1));
                iaddr = $urandom;
            end
            if (!(dren | dwen)) begin
                dren   = 1'($urandom_range(0, 1));
                dwen   = 1'($urandom_range(0, 1));
                daddr  = $urandom;
                dstore = $urandom;
            end
            if (!(iren | dren | dwen)) begin
                iren  = 1'b1;
                iaddr = $urandom;
            end
            do_txn($urandom_range(0, 5), ($urandom_range(0, 3) == 0), $urandom);
        end
        // Drain any loser left pending.
        if (iren | dren | dwen) do_txn(0, 1'b0, $urandom);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_write_busy();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
